// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: turns monitor run/step/stop commands and a PC breakpoint into
// spaced cpu_start / quit_cmd pulses, with a drain hold-off after every quit.
module cpu_run_ctrl #(
    parameter int unsigned PC_W      = 30,
    parameter int unsigned STEP_W    = 16,
    parameter int unsigned DRAIN_CYC = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_start,
    input  logic              cmd_step,
    input  logic [STEP_W-1:0] step_count,
    input  logic              cmd_quit,
    input  logic              bp_set,
    input  logic              bp_clr,
    input  logic [PC_W-1:0]   bp_addr,
    input  logic              pc_adv,
    input  logic [PC_W-1:0]   pc_cur,
    output logic              cpu_start,
    output logic              quit_cmd,
    output logic              cmd_busy,
    output logic              running,
    output logic              step_done,
    output logic              bp_hit
);

    localparam int unsigned DcW = $clog2(DRAIN_CYC + 1);

    typedef enum logic [2:0] {StIdle, StStart, StRun, StQuit, StDrain} state_e;

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic              step_mode_q, step_mode_d;
    logic              mask_q, mask_d;
    logic              bp_en_q, bp_en_d;
    logic [PC_W-1:0]   bp_addr_q, bp_addr_d;
    logic              bp_hit_q, bp_hit_d;
    logic              step_done_q, step_done_d;
    logic [DcW-1:0]    drain_cnt_q, drain_cnt_d;

    logic step_stop;
    logic bp_stop;

    assign step_stop = step_mode_q && pc_adv && (step_cnt_q == STEP_W'(1));
    // The mask suppresses the compare on the first advance so a resume from the bp PC runs on.
    assign bp_stop   = bp_en_q && pc_adv && (pc_cur == bp_addr_q) && !mask_q;

    always_comb begin
        state_d     = state_q;
        step_cnt_d  = step_cnt_q;
        step_mode_d = step_mode_q;
        mask_d      = mask_q;
        bp_en_d     = bp_en_q;
        bp_addr_d   = bp_addr_q;
        bp_hit_d    = bp_hit_q;
        step_done_d = 1'b0;
        drain_cnt_d = drain_cnt_q;

        if (bp_set) begin
            bp_addr_d = bp_addr;
            bp_en_d   = 1'b1;
        end
        if (bp_clr) begin
            bp_en_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (cmd_step && (step_count != '0)) begin
                    state_d     = StStart;
                    step_cnt_d  = step_count;
                    step_mode_d = 1'b1;
                    bp_hit_d    = 1'b0;
                end else if (cmd_start) begin
                    state_d     = StStart;
                    step_mode_d = 1'b0;
                    bp_hit_d    = 1'b0;
                end
            end
            StStart: begin
                mask_d  = 1'b1;
                state_d = StRun;
            end
            StRun: begin
                if (pc_adv) begin
                    mask_d = 1'b0;
                    if (step_mode_q) begin
                        step_cnt_d = step_cnt_q - STEP_W'(1);
                    end
                end
                if (cmd_quit || step_stop || bp_stop) begin
                    state_d     = StQuit;
                    step_done_d = step_stop;
                    if (bp_stop) begin
                        bp_hit_d = 1'b1;
                    end
                end
            end
            StQuit: begin
                drain_cnt_d = '0;
                state_d     = StDrain;
            end
            StDrain: begin
                if (drain_cnt_q == DcW'(DRAIN_CYC - 1)) begin
                    state_d = StIdle;
                end else begin
                    drain_cnt_d = drain_cnt_q + DcW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            step_cnt_q  <= '0;
            step_mode_q <= 1'b0;
            mask_q      <= 1'b0;
            bp_en_q     <= 1'b0;
            bp_addr_q   <= '0;
            bp_hit_q    <= 1'b0;
            step_done_q <= 1'b0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            step_cnt_q  <= step_cnt_d;
            step_mode_q <= step_mode_d;
            mask_q      <= mask_d;
            bp_en_q     <= bp_en_d;
            bp_addr_q   <= bp_addr_d;
            bp_hit_q    <= bp_hit_d;
            step_done_q <= step_done_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    assign cpu_start = (state_q == StStart);
    assign quit_cmd  = (state_q == StQuit);
    assign cmd_busy  = (state_q != StIdle);
    assign running   = (state_q == StRun);
    assign step_done = step_done_q;
    assign bp_hit    = bp_hit_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: expected start/quit pulses are queued as stimulus is driven and
// matched against the DUT pulses by a negedge monitor.
module tb_cpu_run_ctrl;

    localparam int unsigned DRAIN_CYC = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_start, cmd_step, cmd_quit;
    logic [15:0] step_count;
    logic        bp_set, bp_clr;
    logic [29:0] bp_addr, pc_cur;
    logic        pc_adv;
    logic        cpu_start, quit_cmd, cmd_busy, running, step_done, bp_hit;

    typedef struct {
        bit is_quit;
        int cyc;
        bit sd;
        bit bh;
    } exp_t;

    exp_t sb_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    cpu_run_ctrl #(
        .PC_W      (30),
        .STEP_W    (16),
        .DRAIN_CYC (DRAIN_CYC)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_start  (cmd_start),
        .cmd_step   (cmd_step),
        .step_count (step_count),
        .cmd_quit   (cmd_quit),
        .bp_set     (bp_set),
        .bp_clr     (bp_clr),
        .bp_addr    (bp_addr),
        .pc_adv     (pc_adv),
        .pc_cur     (pc_cur),
        .cpu_start  (cpu_start),
        .quit_cmd   (quit_cmd),
        .cmd_busy   (cmd_busy),
        .running    (running),
        .step_done  (step_done),
        .bp_hit     (bp_hit)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_exp(input bit is_quit, input int at, input bit sd, input bit bh);
        exp_t e;
        e.is_quit = is_quit;
        e.cyc     = at;
        e.sd      = sd;
        e.bh      = bh;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Issue a run command in IDLE; returns with the DUT in RUN.
    task automatic start_run(input bit use_step, input logic [15:0] cnt);
        if (use_step) begin
            cmd_step   = 1'b1;
            step_count = cnt;
        end else begin
            cmd_start = 1'b1;
        end
        push_exp(1'b0, cyc + 1, 1'b0, 1'b0);
        tick();
        cmd_start = 1'b0;
        cmd_step  = 1'b0;
        check_val("bp_hit_clr_on_accept", bp_hit, 0);
        check_val("busy_rise", cmd_busy, 1);
        check_val("running_in_start", running, 0);
        tick();
        check_val("running", running, 1);
    endtask

    task automatic adv(input logic [29:0] pc, input bit stop, input bit sd, input bit bh);
        pc_adv = 1'b1;
        pc_cur = pc;
        if (stop) push_exp(1'b1, cyc + 1, sd, bh);
        tick();
        pc_adv = 1'b0;
    endtask

    task automatic quit_drive();
        cmd_quit = 1'b1;
        push_exp(1'b1, cyc + 1, 1'b0, 1'b0);
        tick();
        cmd_quit = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40 && cmd_busy; i++) tick();
        check_val(tag, cmd_busy, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (cpu_start || quit_cmd) begin
            check_val("start_quit_overlap", cpu_start & quit_cmd, 0);
            if (sb_q.size() == 0) begin
                check_val("unexpected_pulse", {30'd0, cpu_start, quit_cmd}, 0);
            end else begin
                e = sb_q.pop_front();
                check_val("pulse_kind", quit_cmd, e.is_quit);
                check_val("pulse_cyc", cyc, e.cyc);
                if (e.is_quit) begin
                    check_val("step_done", step_done, e.sd);
                    check_val("bp_hit", bp_hit, e.bh);
                end
            end
        end else begin
            check_val("stray_step_done", step_done, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cq;
        rst_n = 1'b0;
        {cmd_start, cmd_step, cmd_quit, bp_set, bp_clr, pc_adv} = '0;
        step_count = '0;
        bp_addr    = '0;
        pc_cur     = '0;
        tick();
        tick();
        check_val("rst_cpu_start", cpu_start, 0);
        check_val("rst_quit_cmd", quit_cmd, 0);
        check_val("rst_cmd_busy", cmd_busy, 0);
        check_val("rst_running", running, 0);
        check_val("rst_step_done", step_done, 0);
        check_val("rst_bp_hit", bp_hit, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Free run / stop, with commands ignored in RUN and DRAIN.
        start_run(1'b0, 16'd0);
        repeat (2) tick();
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        check_val("run_ignores_start", running, 1);
        cq = cyc;
        quit_drive();
        tick();
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        while (cyc < cq + DRAIN_CYC + 1) tick();
        check_val("drain_busy_last", cmd_busy, 1);
        tick();
        check_val("drain_idle", cmd_busy, 0);

        // Step with count 0 is ignored.
        cmd_step   = 1'b1;
        step_count = 16'd0;
        tick();
        cmd_step = 1'b0;
        check_val("step0_busy", cmd_busy, 0);
        tick();
        check_val("step0_busy2", cmd_busy, 0);

        // Step 3 with gaps in pc_adv.
        start_run(1'b1, 16'd3);
        adv(30'h100, 1'b0, 1'b0, 1'b0);
        tick();
        adv(30'h101, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        adv(30'h102, 1'b1, 1'b1, 1'b0);
        wait_idle("step3_idle");

        // Breakpoint hit, then resume from the bp PC.
        bp_set  = 1'b1;
        bp_addr = 30'h40;
        tick();
        bp_set = 1'b0;
        start_run(1'b0, 16'd0);
        adv(30'h3E, 1'b0, 1'b0, 1'b0);
        adv(30'h3F, 1'b0, 1'b0, 1'b0);
        adv(30'h40, 1'b1, 1'b0, 1'b1);
        wait_idle("bp_idle");
        check_val("bp_hit_sticky", bp_hit, 1);
        start_run(1'b0, 16'd0);
        adv(30'h40, 1'b0, 1'b0, 1'b0);
        adv(30'h41, 1'b0, 1'b0, 1'b0);
        adv(30'h40, 1'b1, 1'b0, 1'b1);
        wait_idle("bp_rehit_idle");

        // Step expiry and bp match on the same advance.
        start_run(1'b1, 16'd2);
        adv(30'h3F, 1'b0, 1'b0, 1'b0);
        adv(30'h40, 1'b1, 1'b1, 1'b1);
        wait_idle("collide_idle");

        // bp_set with bp_clr leaves the breakpoint disabled.
        bp_set  = 1'b1;
        bp_clr  = 1'b1;
        bp_addr = 30'h40;
        tick();
        bp_set = 1'b0;
        bp_clr = 1'b0;
        start_run(1'b0, 16'd0);
        adv(30'h10, 1'b0, 1'b0, 1'b0);
        adv(30'h40, 1'b0, 1'b0, 1'b0);
        adv(30'h40, 1'b0, 1'b0, 1'b0);
        check_val("bp_disabled_running", running, 1);
        quit_drive();
        wait_idle("bpclr_idle");
        check_val("bpclr_no_hit", bp_hit, 0);

        // Async reset while running: outputs drop at once, no quit pulse.
        start_run(1'b0, 16'd0);
        adv(30'h20, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_running", running, 0);
        check_val("arst_busy", cmd_busy, 0);
        check_val("arst_quit", quit_cmd, 0);
        check_val("arst_start", cpu_start, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        start_run(1'b0, 16'd0);
        quit_drive();
        wait_idle("post_rst_idle");

        tick();
        check_val("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
